// File: rtl/subset_scan_driver.sv
// subset_scan_driver: requesting side of the subset-evaluator interface.
// On start it latches one configuration and walks every grid position
// row-major (x fastest). It issues one request per position and counts the
// evaluator's activated responses. A stalled request aborts the scan with a
// sticky timeout flag.
// Ports:
//   clk, rst (sync, active-high)
//   start, cfg_central[24], cfg_radius_square[24], cfg_mode[2] : scan request/config
//   en, central, radius_square, mode, position                 : evaluator request
//   valid, activated                                            : evaluator response
//   busy, done, count, timeout_err                              : scan status
module subset_scan_driver #(
  parameter int unsigned GRID    = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] cfg_central,
  input  logic [23:0] cfg_radius_square,
  input  logic [1:0]  cfg_mode,
  output logic        en,
  output logic [23:0] central,
  output logic [23:0] radius_square,
  output logic [1:0]  mode,
  output logic [7:0]  position,
  input  logic        valid,
  input  logic        activated,
  output logic        busy,
  output logic        done,
  output logic [7:0]  count,
  output logic        timeout_err
);

  localparam int unsigned CW  = 4;
  localparam int unsigned WCW = 8;
  localparam logic [CW-1:0]  GRID_C    = CW'(GRID);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     pos_q, pos_d;
  logic [7:0]     count_q, count_d;
  logic           err_q, err_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [23:0]    central_q, central_d;
  logic [23:0]    radius_q, radius_d;
  logic [1:0]     mode_q, mode_d;
  logic           en_q, busy_q, done_q;

  logic [CW-1:0] x_cur, y_cur;
  assign x_cur = pos_q[7:4];
  assign y_cur = pos_q[3:0];

  // Next-state and next-register values
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    count_d   = count_q;
    err_d     = err_q;
    wait_d    = wait_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          central_d = cfg_central;
          radius_d  = cfg_radius_square;
          mode_d    = cfg_mode;
          pos_d     = {4'd1, 4'd1};
          count_d   = 8'd0;
          err_d     = 1'b0;
          wait_d    = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (valid) begin
          count_d = count_q + 8'(activated);
          if (x_cur == GRID_C && y_cur == GRID_C) begin
            state_d = DONE;
          end else begin
            // x runs fastest; wrap to 1 and step y at the row end
            if (x_cur == GRID_C) pos_d = {4'd1, y_cur + 4'd1};
            else                 pos_d = {x_cur + 4'd1, y_cur};
            state_d = ISSUE;
          end
        end else begin
          wait_d = wait_q + WCW'(1);
          // this stalled cycle is the TIMEOUT-th one
          if (wait_q == WAIT_LAST) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, strobes decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_q     <= 8'd0;
      count_q   <= 8'd0;
      err_q     <= 1'b0;
      wait_q    <= '0;
      central_q <= 24'd0;
      radius_q  <= 24'd0;
      mode_q    <= 2'd0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      en_q      <= (state_d == ISSUE);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign en            = en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign position      = pos_q;
  assign count         = count_q;
  assign timeout_err   = err_q;
  assign central       = central_q;
  assign radius_square = radius_q;
  assign mode          = mode_q;

endmodule

// File: tb/tb_subset_scan_driver.sv
// Bench for subset_scan_driver: a GRID=8 and a GRID=1 instance driven by a
// behavioural evaluator with programmable latency, activation rule and stall.
module tb_subset_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start1 = 1'b0;
  logic [23:0] cfg_central = 24'd0, cfg_radius_square = 24'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        ev_valid = 1'b0, ev_act = 1'b0;

  logic        en8, busy8, done8, err8, en1, busy1, done1, err1;
  logic [23:0] cen8, rad8, cen1, rad1;
  logic [1:0]  mode8, mode1;
  logic [7:0]  pos8, cnt8, pos1, cnt1;

  always #5 clk = ~clk;

  subset_scan_driver #(.GRID(8), .TIMEOUT(16)) u8 (
    .clk(clk), .rst(rst), .start(start8), .cfg_central(cfg_central),
    .cfg_radius_square(cfg_radius_square), .cfg_mode(cfg_mode), .en(en8),
    .central(cen8), .radius_square(rad8), .mode(mode8), .position(pos8),
    .valid(ev_valid), .activated(ev_act), .busy(busy8), .done(done8),
    .count(cnt8), .timeout_err(err8));

  subset_scan_driver #(.GRID(1), .TIMEOUT(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_central(cfg_central),
    .cfg_radius_square(cfg_radius_square), .cfg_mode(cfg_mode), .en(en1),
    .central(cen1), .radius_square(rad1), .mode(mode1), .position(pos1),
    .valid(ev_valid), .activated(ev_act), .busy(busy1), .done(done1),
    .count(cnt1), .timeout_err(err1));

  bit         sel = 1'b0;
  logic       o_en, o_busy, o_done, o_err;
  logic [7:0] o_pos, o_cnt;
  assign o_en   = sel ? en1   : en8;
  assign o_busy = sel ? busy1 : busy8;
  assign o_done = sel ? done1 : done8;
  assign o_err  = sel ? err1  : err8;
  assign o_pos  = sel ? pos1  : pos8;
  assign o_cnt  = sel ? cnt1  : cnt8;

  int total = 0;
  int bad   = 0;

  // Evaluator model
  int         lat = 1;
  int         amode = 0;
  logic [7:0] stall_pos = 8'h00;
  bit         pend = 1'b0;
  int         wl = 0;
  logic [7:0] plat = 8'h00;

  function automatic logic act_fn(input logic [7:0] p);
    logic [3:0] x, y;
    x = p[7:4];
    y = p[3:0];
    case (amode)
      0: return 1'b1;
      1: return (x == y);
      default: return x[0] ^ y[0];
    endcase
  endfunction

  always @(posedge clk) begin
    ev_valid <= 1'b0;
    ev_act   <= 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (o_en) begin
      if (o_pos != stall_pos) begin
        pend = 1'b1;
        wl   = lat - 1;
        plat = o_pos;
      end
    end else if (pend) begin
      wl = wl - 1;
    end
    if (pend && wl == 0) begin
      ev_valid <= 1'b1;
      ev_act   <= act_fn(plat);
      pend = 1'b0;
    end
  end

  // Runs one scan; expected positions are queued up front and popped on each en.
  task automatic run_scan(input bit g1, input bit glitch, input int rst_at,
                          output int en_cnt, output int done_cyc,
                          output int done_cnt, output bit rst_hit);
    logic [7:0] q[$];
    logic [7:0] p, exp_p;
    int g, cyc, tail;
    bit stop;
    g = g1 ? 1 : 8;
    sel = g1;
    stop = 1'b0;
    for (int y = 1; y <= g; y++)
      for (int x = 1; x <= g; x++)
        if (!stop) begin
          p = {4'(x), 4'(y)};
          q.push_back(p);
          if (p == stall_pos) stop = 1'b1;
        end
    @(negedge clk);
    if (g1) start1 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start8 = 1'b0;
    cyc = 1;
    en_cnt = 0; done_cyc = 0; done_cnt = 0; tail = -1; rst_hit = 1'b0;
    while (cyc < 600 && tail != 0) begin
      if (o_en) begin
        en_cnt++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL en_extra cyc=%0d pos=%h (no request expected)", cyc, o_pos);
        end else begin
          exp_p = q.pop_front();
          if (o_pos !== exp_p) begin
            bad++;
            $display("FAIL en_position cyc=%0d got=%h exp=%h", cyc, o_pos, exp_p);
          end
        end
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          tail = 6;
        end
      end
      if (glitch && cyc >= 3 && cyc < 100 && cyc % 7 == 0) begin
        start8 = 1'b1;
        cfg_central = 24'($urandom);
        cfg_radius_square = 24'($urandom);
        cfg_mode = 2'($urandom);
      end else begin
        start8 = 1'b0;
      end
      if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
      if (rst_at > 0 && cyc == rst_at + 1) begin
        rst_hit = 1'b1;
        rst = 1'b0;
        break;
      end
      if (tail > 0) tail--;
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (en8 !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", en8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done8); end
    total++; if (cnt8 !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt8); end
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err8); end
    total++; if (pos8 !== 8'd0) begin bad++; $display("FAIL reset_pos got=%h exp=00", pos8); end
    total++; if ({cen8, rad8, mode8} !== 50'd0) begin bad++; $display("FAIL reset_cfg got=%h exp=0", {cen8, rad8, mode8}); end
    total++; if ({en1, busy1, done1, cnt1, pos1} !== 19'd0) begin bad++; $display("FAIL reset_g1 got=%h exp=0", {en1, busy1, done1, cnt1, pos1}); end
  endtask

  task automatic test_full_l1;
    int n, dc, dn;
    bit rh;
    lat = 1; amode = 0; stall_pos = 8'h00;
    cfg_central = 24'h123456; cfg_radius_square = 24'h0A1B2C; cfg_mode = 2'd2;
    run_scan(1'b0, 1'b0, 0, n, dc, dn, rh);
    total++; if (n !== 64) begin bad++; $display("FAIL full_en_count got=%0d exp=64", n); end
    total++; if (dc !== 129) begin bad++; $display("FAIL full_done_cycle got=%0d exp=129", dc); end
    total++; if (dn !== 1) begin bad++; $display("FAIL full_done_pulses got=%0d exp=1", dn); end
    total++; if (cnt8 !== 8'd64) begin bad++; $display("FAIL full_count got=%0d exp=64", cnt8); end
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL full_err got=%b exp=0", err8); end
    total++; if (pos8 !== 8'h88) begin bad++; $display("FAIL full_pos got=%h exp=88", pos8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL full_busy_after got=%b exp=0", busy8); end
    total++; if ({cen8, rad8, mode8} !== {24'h123456, 24'h0A1B2C, 2'd2}) begin
      bad++; $display("FAIL full_cfg got=%h exp=%h", {cen8, rad8, mode8}, {24'h123456, 24'h0A1B2C, 2'd2}); end
  endtask

  task automatic test_diag_l3;
    int n, dc, dn;
    bit rh;
    lat = 3; amode = 1; stall_pos = 8'h00;
    run_scan(1'b0, 1'b0, 0, n, dc, dn, rh);
    total++; if (n !== 64) begin bad++; $display("FAIL diag_en_count got=%0d exp=64", n); end
    total++; if (dc !== 257) begin bad++; $display("FAIL diag_done_cycle got=%0d exp=257", dc); end
    total++; if (cnt8 !== 8'd8) begin bad++; $display("FAIL diag_count got=%0d exp=8", cnt8); end
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL diag_err got=%b exp=0", err8); end
  endtask

  task automatic test_timeout;
    int n, dc, dn;
    bit rh;
    lat = 1; amode = 2; stall_pos = 8'h51;
    run_scan(1'b0, 1'b0, 0, n, dc, dn, rh);
    // 5th request issued at cycle 1+4*2=9, abort 17 cycles later
    total++; if (n !== 5) begin bad++; $display("FAIL to_en_count got=%0d exp=5", n); end
    total++; if (dc !== 26) begin bad++; $display("FAIL to_done_cycle got=%0d exp=26", dc); end
    total++; if (err8 !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", err8); end
    total++; if (cnt8 !== 8'd2) begin bad++; $display("FAIL to_count got=%0d exp=2", cnt8); end
    total++; if (pos8 !== 8'h51) begin bad++; $display("FAIL to_pos got=%h exp=51", pos8); end
    stall_pos = 8'h00;
  endtask

  task automatic test_restart_ignored;
    int n, dc, dn;
    bit rh;
    lat = 1; amode = 0; stall_pos = 8'h00;
    cfg_central = 24'hABCDEF; cfg_radius_square = 24'h112233; cfg_mode = 2'd1;
    run_scan(1'b0, 1'b1, 0, n, dc, dn, rh);
    total++; if (dn !== 1) begin bad++; $display("FAIL restart_done_pulses got=%0d exp=1", dn); end
    total++; if (dc !== 129) begin bad++; $display("FAIL restart_done_cycle got=%0d exp=129", dc); end
    total++; if (n !== 64) begin bad++; $display("FAIL restart_en_count got=%0d exp=64", n); end
    total++; if ({cen8, rad8, mode8} !== {24'hABCDEF, 24'h112233, 2'd1}) begin
      bad++; $display("FAIL restart_cfg got=%h exp=%h", {cen8, rad8, mode8}, {24'hABCDEF, 24'h112233, 2'd1}); end
  endtask

  task automatic test_mid_reset;
    int n, dc, dn;
    bit rh;
    lat = 1; amode = 0; stall_pos = 8'h00;
    run_scan(1'b0, 1'b0, 40, n, dc, dn, rh);
    total++; if (rh !== 1'b1) begin bad++; $display("FAIL mrst_reached got=%b exp=1", rh); end
    total++; if (dn !== 0) begin bad++; $display("FAIL mrst_done_pulses got=%0d exp=0", dn); end
    total++; if ({en8, busy8, done8, err8, cnt8, pos8} !== 20'd0) begin
      bad++; $display("FAIL mrst_outputs got=%h exp=0", {en8, busy8, done8, err8, cnt8, pos8}); end
    total++; if ({cen8, rad8, mode8} !== 50'd0) begin bad++; $display("FAIL mrst_cfg got=%h exp=0", {cen8, rad8, mode8}); end
    amode = 1;
    run_scan(1'b0, 1'b0, 0, n, dc, dn, rh);
    total++; if (dc !== 129) begin bad++; $display("FAIL mrst_rescan_done got=%0d exp=129", dc); end
    total++; if (cnt8 !== 8'd8) begin bad++; $display("FAIL mrst_rescan_count got=%0d exp=8", cnt8); end
  endtask

  task automatic test_grid1;
    int n, dc, dn;
    bit rh;
    lat = 2; amode = 0; stall_pos = 8'h00;
    run_scan(1'b1, 1'b0, 0, n, dc, dn, rh);
    total++; if (n !== 1) begin bad++; $display("FAIL g1_en_count got=%0d exp=1", n); end
    total++; if (dc !== 4) begin bad++; $display("FAIL g1_done_cycle got=%0d exp=4", dc); end
    total++; if (cnt1 !== 8'd1) begin bad++; $display("FAIL g1_count got=%0d exp=1", cnt1); end
    total++; if (pos1 !== 8'h11) begin bad++; $display("FAIL g1_pos got=%h exp=11", pos1); end
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_full_l1;
    test_diag_l3;
    test_timeout;
    test_restart_ignored;
    test_mid_reset;
    test_grid1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/subset_scan_driver.md
# subset_scan_driver

Requesting end of the subset-evaluator interface. On `start`, it latches one configuration: three circle centres, three squared radii and a mode. It then walks every grid position, issuing one request per position to a subset evaluator and collecting the evaluator's `valid`/`activated` response, and reports the number of activated positions when the scan completes. It sits between the configuration/control logic and the evaluator, and it owns sequencing, response handshaking and timeout detection.

## Interface
Parameters:
- `GRID`, default 8: grid edge length; coordinates run 1..GRID on both axes; legal range 1..15.
- `TIMEOUT`, default 16: maximum number of WAIT cycles allowed per request before the scan aborts; legal range 1..255.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: begin a scan; sampled only in IDLE.
- `cfg_central`, input, 24: {xA,yA,xB,yB,xC,yC}, 4 bits each, MSB first.
- `cfg_radius_square`, input, 24: {rA², rB², rC²}, 8 bits each, MSB first.
- `cfg_mode`, input, 2: subset-combination select; passed through unchanged.
- `en`, output, 1: request strobe to the evaluator; one-cycle pulse per position.
- `central`, output, 24: latched `cfg_central`.
- `radius_square`, output, 24: latched `cfg_radius_square`.
- `mode`, output, 2: latched `cfg_mode`.
- `position`, output, 8: {x[7:4], y[3:0]} of the current request.
- `valid`, input, 1: evaluator response strobe.
- `activated`, input, 1: evaluator result; qualified by `valid`.
- `busy`, output, 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done`, output, 1: one-cycle pulse at scan end, whether the scan completed or timed out.
- `count`, output, 8: number of positions with `activated` high.
- `timeout_err`, output, 1: sticky; set when a request times out.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: `en`=0 and `busy`=0.
  - On `start`=1: latch the cfg inputs into `central`, `radius_square` and `mode`.
  - Set `position` to {1,1}, clear `count` and `timeout_err`, clear the wait counter, and go to ISSUE.
- While busy, `start` and the cfg inputs are ignored.
- ISSUE: `en`=1 for exactly this cycle with the current `position`; clear the wait counter; go to WAIT.
  - `valid` in an ISSUE cycle is ignored. The evaluator latency is at least 1 cycle.
- WAIT, when `valid`=1:
  - `count` <= `count` + `activated`.
  - If `position` is {GRID,GRID}, go to DONE.
  - Otherwise advance `position` and go to ISSUE.
- WAIT, when `valid`=0: increment the wait counter.
  - When the counter reaches TIMEOUT, set `timeout_err`, leave `position` and `count` unchanged, and go to DONE.
- Position order: x increments first. At x=GRID, x wraps to 1 and y increments. The scan is row-major over GRID×GRID positions.
- DONE: `done`=1 and `busy`=1 for one cycle, then go to IDLE.
- `count`, `timeout_err`, `position` and the latched configuration hold their values in IDLE until the next accepted `start`.
- `count` does not wrap. The maximum is 225, which fits in 8 bits.
- `valid` outside WAIT has no effect, including a late response after a timeout.

## Timing
- Reset values: state IDLE; `en`=0, `busy`=0, `done`=0, `count`=0, `timeout_err`=0, `position`=0, `central`=0, `radius_square`=0, `mode`=0.
- `rst` mid-scan aborts immediately to the reset values on the next edge, with no `done` pulse. `rst` takes priority over every other input.
- Cycle numbering, with `start` sampled at edge 0:
  - ISSUE is cycle 1.
  - With evaluator latency L (L ≥ 1 cycles after `en`), `valid` is seen in WAIT at cycle 1+L.
  - Cost per position is 1+L cycles.
- Full scan: `done` is asserted at cycle GRID²·(1+L)+1.
- Timeout: `timeout_err` and `done` are asserted TIMEOUT+1 cycles after the ISSUE cycle of the stalled request.
- All outputs are registered.

## Test plan
- GRID=8, evaluator L=1 with `activated`=1 always, `start` at cycle 0 -> 64 `en` pulses; `done` at cycle 129; `count`=64; `timeout_err`=0.
- Evaluator with L=3 and `activated`=1 only where x==y -> positions go {1,1},{2,1}..{8,1},{1,2}..{8,8}; `done` at cycle 257; `count`=8.
- Evaluator never returns `valid` on the 5th request ({5,1}), TIMEOUT=16 -> `timeout_err`=1; `done` 17 cycles after that ISSUE; `count`=number activated in the first 4 positions; `position`={5,1}.
- `start` pulsed repeatedly and cfg inputs changed mid-scan -> the scan is not restarted; `central`, `radius_square` and `mode` keep their start-time values; only one `done`.
- `rst` asserted at cycle 40 of a scan -> the next cycle has all outputs at reset values and no `done`; a new `start` then completes normally with `count` cleared.
- GRID=1 -> a single `en` with `position`={1,1}; `done` at cycle 2+L; `count`=`activated` of that single response.
